// File: rtl/instr_encoder.sv
// instr_encoder: packs instruction field requests into 32-bit words
// and writes them sequentially into instruction memory.
module instr_encoder #(
  parameter int ADDR_W     = 6,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [5:0]        in_funct,
  input  logic [3:0]        in_cond,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rd,
  input  logic [11:0]       in_src2,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W:0]   CAP   = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    ENC,
    WRITE,
    DONE
  } state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic [5:0]  funct_q;
  logic [3:0]  cond_q;
  logic [3:0]  rn_q;
  logic [3:0]  rd_q;
  logic [11:0] src2_q;
  logic        last_q;

  logic [5:0]      funct_l;
  logic [3:0]      rd_l;
  logic [31:0]     word;
  logic [ADDR_W:0] count_nxt;
  logic            cap_hit;

  assign in_ready  = (state == IDLE);
  assign count_nxt = count + 1'b1;
  assign cap_hit   = (count_nxt == CAP);

  // Legalise the latched fields and pack the instruction word
  always_comb begin
    funct_l = funct_q;
    rd_l    = rd_q;
    case (op_q)
      2'b00: begin
        if (funct_q[4:1] == 4'b1010) begin
          funct_l[0] = 1'b1;
          rd_l       = 4'd0;
        end
      end
      2'b10:   funct_l[5] = 1'b1;
      default: ;
    endcase
    word = {cond_q, op_q, funct_l, rn_q, rd_l, src2_q};
  end

  // Control FSM with registered write port and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= START;
      mem_wdata <= '0;
      count     <= '0;
      done      <= 1'b0;
      full      <= 1'b0;
      err       <= 1'b0;
      op_q      <= '0;
      funct_q   <= '0;
      cond_q    <= '0;
      rn_q      <= '0;
      rd_q      <= '0;
      src2_q    <= '0;
      last_q    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q    <= in_op;
            funct_q <= in_funct;
            cond_q  <= in_cond;
            rn_q    <= in_rn;
            rd_q    <= in_rd;
            src2_q  <= in_src2;
            last_q  <= in_last;
            state   <= ENC;
          end
        end
        ENC: begin
          if (op_q == 2'b11) begin
            err <= 1'b1;
            if (last_q) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= IDLE;
            end
          end else begin
            mem_wdata <= word;
            mem_we    <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          mem_addr <= mem_addr + 1'b1;
          count    <= count_nxt;
          if (cap_hit) full <= 1'b1;
          if (last_q || cap_hit) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= IDLE;
          end
        end
        DONE: begin
          if (restart) begin
            state    <= IDLE;
            mem_addr <= START;
            count    <= '0;
            done     <= 1'b0;
            full     <= 1'b0;
            err      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed checks of instr_encoder packing,
// legalisation, sequencing, capacity and reset behaviour.
module tb_instr_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1;
  logic        rst_b = 1'b1;
  logic        restart = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_op = '0;
  logic [5:0]  in_funct = '0;
  logic [3:0]  in_cond = '0;
  logic [3:0]  in_rn = '0;
  logic [3:0]  in_rd = '0;
  logic [11:0] in_src2 = '0;
  logic        in_last = 1'b0;

  logic        ready_a, we_a, done_a, full_a, err_a;
  logic [5:0]  addr_a;
  logic [31:0] wdata_a;
  logic [6:0]  count_a;

  logic        ready_b, we_b, done_b, full_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;
  logic [2:0]  count_b;

  int vec = 0;
  int bad = 0;
  int we_a_n = 0;
  int we_b_n = 0;

  instr_encoder #(.ADDR_W(6), .START_ADDR(0)) dut_a (
    .clk(clk), .reset(rst_a), .restart(restart),
    .in_valid(in_valid), .in_ready(ready_a),
    .in_op(in_op), .in_funct(in_funct), .in_cond(in_cond),
    .in_rn(in_rn), .in_rd(in_rd), .in_src2(in_src2),
    .in_last(in_last), .mem_we(we_a), .mem_addr(addr_a),
    .mem_wdata(wdata_a), .count(count_a), .done(done_a),
    .full(full_a), .err(err_a)
  );

  instr_encoder #(.ADDR_W(2), .START_ADDR(0)) dut_b (
    .clk(clk), .reset(rst_b), .restart(restart),
    .in_valid(in_valid), .in_ready(ready_b),
    .in_op(in_op), .in_funct(in_funct), .in_cond(in_cond),
    .in_rn(in_rn), .in_rd(in_rd), .in_src2(in_src2),
    .in_last(in_last), .mem_we(we_b), .mem_addr(addr_b),
    .mem_wdata(wdata_b), .count(count_b), .done(done_b),
    .full(full_b), .err(err_b)
  );

  // count write strobes, sampled mid-cycle
  always @(negedge clk) begin
    #2;
    if (we_a === 1'b1) we_a_n++;
    if (we_b === 1'b1) we_b_n++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // drive one request; returns at the negedge of the ENC cycle
  task automatic send(input bit b, input logic [1:0] op,
                      input logic [5:0] f, input logic [3:0] c,
                      input logic [3:0] rn, input logic [3:0] rd,
                      input logic [11:0] s, input logic last);
    int w;
    @(negedge clk);
    in_op = op; in_funct = f; in_cond = c;
    in_rn = rn; in_rd = rd; in_src2 = s;
    in_last = last; in_valid = 1'b1;
    w = 0;
    while (!(b ? ready_b : ready_a) && w < 20) begin
      @(negedge clk);
      w++;
    end
    vec++;
    if ((b ? ready_b : ready_a) !== 1'b1) begin
      bad++;
      $display("FAIL accept_timeout ready=0 required 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic pulse_reset_a;
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    vec++;
    if ({ready_a, we_a, done_a, full_a, err_a} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_flags got %b required 10000",
               {ready_a, we_a, done_a, full_a, err_a});
    end
    vec++;
    if (addr_a !== 6'd0 || count_a !== 7'd0 || wdata_a !== 32'd0) begin
      bad++;
      $display("FAIL reset_regs addr=%0d count=%0d wdata=%h required 0/0/0",
               addr_a, count_a, wdata_a);
    end
  endtask

  task automatic test_dp_add;
    send(0, 2'b00, 6'b001000, 4'hE, 4'd1, 4'd2, 12'h003, 1'b0);
    vec++;
    if (we_a !== 1'b0) begin
      bad++;
      $display("FAIL add_early_we got %b required 0", we_a);
    end
    @(negedge clk);
    vec++;
    if (we_a !== 1'b1 || addr_a !== 6'd0 || wdata_a !== 32'hE0812003) begin
      bad++;
      $display("FAIL add_write we=%b addr=%0d wdata=%h required 1/0/e0812003",
               we_a, addr_a, wdata_a);
    end
    @(negedge clk);
    vec++;
    if (we_a !== 1'b0 || count_a !== 7'd1 || addr_a !== 6'd1 ||
        ready_a !== 1'b1 || done_a !== 1'b0) begin
      bad++;
      $display("FAIL add_after we=%b count=%0d addr=%0d ready=%b done=%b required 0/1/1/1/0",
               we_a, count_a, addr_a, ready_a, done_a);
    end
  endtask

  task automatic test_cmp;
    send(0, 2'b00, 6'b010100, 4'hE, 4'd3, 4'd5, 12'h004, 1'b0);
    @(negedge clk);
    vec++;
    if (we_a !== 1'b1 || addr_a !== 6'd1 || wdata_a !== 32'hE1530004) begin
      bad++;
      $display("FAIL cmp_write we=%b addr=%0d wdata=%h required 1/1/e1530004",
               we_a, addr_a, wdata_a);
    end
    @(negedge clk);
    vec++;
    if (count_a !== 7'd2) begin
      bad++;
      $display("FAIL cmp_count got %0d required 2", count_a);
    end
  endtask

  task automatic test_forms;
    logic [1:0]  op [3] = '{2'b01, 2'b10, 2'b01};
    logic [5:0]  fn [3] = '{6'b000001, 6'b000011, 6'b010100};
    logic [3:0]  cd [3] = '{4'hE, 4'h0, 4'hE};
    logic [3:0]  rn [3] = '{4'h4, 4'hA, 4'h3};
    logic [3:0]  rd [3] = '{4'h7, 4'hB, 4'h5};
    logic [11:0] s2 [3] = '{12'h010, 12'h123, 12'h004};
    logic [31:0] ex [3] = '{32'hE4147010, 32'h0A3AB123, 32'hE5435004};
    for (int k = 0; k < 3; k++) begin
      send(0, op[k], fn[k], cd[k], rn[k], rd[k], s2[k], 1'b0);
      @(negedge clk);
      vec++;
      if (we_a !== 1'b1 || addr_a !== 6'(k + 2) || wdata_a !== ex[k]) begin
        bad++;
        $display("FAIL form%0d we=%b addr=%0d wdata=%h required 1/%0d/%h",
                 k, we_a, addr_a, wdata_a, k + 2, ex[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal;
    int n0;
    pulse_reset_a();
    send(0, 2'b00, 6'b001000, 4'hE, 4'd1, 4'd2, 12'h003, 1'b0);
    repeat (2) @(negedge clk);
    n0 = we_a_n;
    send(0, 2'b11, 6'b000000, 4'hE, 4'd1, 4'd2, 12'h003, 1'b0);
    repeat (3) @(negedge clk);
    vec++;
    if (we_a_n !== n0) begin
      bad++;
      $display("FAIL illegal_write strobes=%0d required %0d", we_a_n, n0);
    end
    vec++;
    if (err_a !== 1'b1 || count_a !== 7'd1 || addr_a !== 6'd1 || ready_a !== 1'b1) begin
      bad++;
      $display("FAIL illegal_state err=%b count=%0d addr=%0d ready=%b required 1/1/1/1",
               err_a, count_a, addr_a, ready_a);
    end
    send(0, 2'b00, 6'b000101, 4'hE, 4'd1, 4'd3, 12'h0FF, 1'b0);
    @(negedge clk);
    vec++;
    if (we_a !== 1'b1 || addr_a !== 6'd1 || wdata_a !== 32'hE05130FF) begin
      bad++;
      $display("FAIL illegal_next we=%b addr=%0d wdata=%h required 1/1/e05130ff",
               we_a, addr_a, wdata_a);
    end
    @(negedge clk);
    vec++;
    if (count_a !== 7'd2 || err_a !== 1'b1) begin
      bad++;
      $display("FAIL illegal_count count=%0d err=%b required 2/1", count_a, err_a);
    end
    n0 = we_a_n;
    send(0, 2'b11, 6'b000000, 4'h0, 4'd0, 4'd0, 12'h000, 1'b1);
    repeat (2) @(negedge clk);
    vec++;
    if (done_a !== 1'b1 || ready_a !== 1'b0 || count_a !== 7'd2 || we_a_n !== n0) begin
      bad++;
      $display("FAIL illegal_last done=%b ready=%b count=%0d strobes=%0d required 1/0/2/%0d",
               done_a, ready_a, count_a, we_a_n, n0);
    end
  endtask

  task automatic test_program_restart;
    pulse_reset_a();
    for (int k = 0; k < 3; k++) begin
      send(0, 2'b00, 6'b001000, 4'hE, 4'(k), 4'(k + 1), 12'(k), k == 2);
      @(negedge clk);
      vec++;
      if (we_a !== 1'b1 || addr_a !== 6'(k) ||
          wdata_a !== {4'hE, 2'b00, 6'b001000, 4'(k), 4'(k + 1), 12'(k)}) begin
        bad++;
        $display("FAIL prog_word%0d we=%b addr=%0d wdata=%h", k, we_a, addr_a, wdata_a);
      end
      @(negedge clk);
      if (k == 1) begin
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        vec++;
        if (count_a !== 7'd2 || addr_a !== 6'd2) begin
          bad++;
          $display("FAIL restart_ignored count=%0d addr=%0d required 2/2", count_a, addr_a);
        end
      end
    end
    repeat (2) @(negedge clk);
    vec++;
    if (done_a !== 1'b1 || ready_a !== 1'b0 || count_a !== 7'd3 || addr_a !== 6'd3) begin
      bad++;
      $display("FAIL prog_done done=%b ready=%b count=%0d addr=%0d required 1/0/3/3",
               done_a, ready_a, count_a, addr_a);
    end
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    vec++;
    if ({done_a, ready_a, full_a, err_a} !== 4'b0100 ||
        count_a !== 7'd0 || addr_a !== 6'd0) begin
      bad++;
      $display("FAIL restart done=%b ready=%b count=%0d addr=%0d required 0/1/0/0",
               done_a, ready_a, count_a, addr_a);
    end
    send(0, 2'b00, 6'b001000, 4'hE, 4'd1, 4'd2, 12'h003, 1'b0);
    @(negedge clk);
    vec++;
    if (we_a !== 1'b1 || addr_a !== 6'd0 || wdata_a !== 32'hE0812003) begin
      bad++;
      $display("FAIL restart_write we=%b addr=%0d wdata=%h required 1/0/e0812003",
               we_a, addr_a, wdata_a);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write;
    int n0;
    pulse_reset_a();
    send(0, 2'b00, 6'b001000, 4'hE, 4'd1, 4'd2, 12'h003, 1'b0);
    repeat (2) @(negedge clk);
    send(0, 2'b00, 6'b000101, 4'hE, 4'd1, 4'd3, 12'h0FF, 1'b0);
    @(negedge clk);
    vec++;
    if (we_a !== 1'b1) begin
      bad++;
      $display("FAIL midw_pre we=%b required 1", we_a);
    end
    rst_a = 1'b1;
    restart = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    restart = 1'b0;
    vec++;
    if (we_a !== 1'b0 || ready_a !== 1'b1 || count_a !== 7'd0 ||
        addr_a !== 6'd0 || wdata_a !== 32'd0 || done_a !== 1'b0) begin
      bad++;
      $display("FAIL midw_reset we=%b ready=%b count=%0d addr=%0d wdata=%h required 0/1/0/0/0",
               we_a, ready_a, count_a, addr_a, wdata_a);
    end
    n0 = we_a_n;
    repeat (4) @(negedge clk);
    vec++;
    if (we_a_n !== n0 || count_a !== 7'd0) begin
      bad++;
      $display("FAIL midw_quiet strobes=%0d count=%0d required %0d/0", we_a_n, count_a, n0);
    end
  endtask

  task automatic test_full;
    bit quiet;
    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send(1, 2'b00, 6'b001000, 4'hE, 4'(k), 4'(k), 12'(k), 1'b0);
      @(negedge clk);
      vec++;
      if (we_b !== 1'b1 || addr_b !== 2'(k)) begin
        bad++;
        $display("FAIL full_write%0d we=%b addr=%0d required 1/%0d", k, we_b, addr_b, k);
      end
      @(negedge clk);
    end
    vec++;
    if ({full_b, done_b, ready_b} !== 3'b110 || count_b !== 3'd4 || addr_b !== 2'd0) begin
      bad++;
      $display("FAIL full_flags full=%b done=%b ready=%b count=%0d addr=%0d required 1/1/0/4/0",
               full_b, done_b, ready_b, count_b, addr_b);
    end
    in_op = 2'b00;
    in_valid = 1'b1;
    quiet = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (ready_b !== 1'b0) quiet = 1'b0;
    end
    in_valid = 1'b0;
    @(negedge clk);
    vec++;
    if (quiet !== 1'b1 || we_b_n !== 4) begin
      bad++;
      $display("FAIL full_fifth ready_stayed_low=%b strobes=%0d required 1/4", quiet, we_b_n);
    end
  endtask

  initial begin
    test_reset();
    test_dp_add();
    test_cmp();
    test_forms();
    test_illegal();
    test_program_restart();
    test_reset_mid_write();
    test_full();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
